// File: rtl/sar_adc_if.sv
// Bus between the SAR controller and its environment: the digital request side
// (start/abort), the analog front end (sample/dac_code/cmp_in) and the result side.
//   start    conversion request
//   abort    synchronous abort
//   cmp_in   comparator decision, 1 = input >= DAC output
//   sample   track/hold control, 1 = track
//   dac_code trial code to the DAC
//   busy     conversion in progress
//   done     one-cycle completion pulse
//   result   last completed conversion
//   sat      (SAR_SATFLAG_EN only) result is at either rail
// Optional feature macro: SAR_SATFLAG_EN.
interface sar_adc_if #(parameter int NBITS = 8);
  logic             start;
  logic             abort;
  logic             cmp_in;
  logic             sample;
  logic [NBITS-1:0] dac_code;
  logic             busy;
  logic             done;
  logic [NBITS-1:0] result;
`ifdef SAR_SATFLAG_EN
  logic             sat;

  modport master (output start, abort, cmp_in,
                  input  sample, dac_code, busy, done, result, sat);
  modport slave  (input  start, abort, cmp_in,
                  output sample, dac_code, busy, done, result, sat);
`else
  modport master (output start, abort, cmp_in,
                  input  sample, dac_code, busy, done, result);
  modport slave  (input  start, abort, cmp_in,
                  output sample, dac_code, busy, done, result);
`endif
endinterface

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller.
// Tracks for SAMPLE_CYCLES, then tests one bit per trial (MSB first), holding each
// trial code SETTLE_CYCLES before using the comparator decision.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    sar_adc_if slave: start/abort/cmp_in in; sample/dac_code/busy/done/result out
// Optional feature macro: SAR_SATFLAG_EN adds bus.sat, set at done when the result
// is all-zeros or all-ones.
module sar_adc_ctrl #(
  parameter int NBITS         = 8,
  parameter int SAMPLE_CYCLES = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  sar_adc_if.slave  bus
);

  localparam int CMAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = $clog2(NBITS);

  typedef enum logic [1:0] {IDLE, SAMPLE, TRIAL, DONE} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [IW-1:0]    idx, idx_n;
  logic [NBITS-1:0] code, code_n;
  logic [NBITS-1:0] res, res_n;
`ifdef SAR_SATFLAG_EN
  logic             sat, sat_n;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      code  <= '0;
      res   <= '0;
`ifdef SAR_SATFLAG_EN
      sat   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      code  <= code_n;
      res   <= res_n;
`ifdef SAR_SATFLAG_EN
      sat   <= sat_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    code_n  = code;
    res_n   = res;
`ifdef SAR_SATFLAG_EN
    sat_n   = sat;
`endif
    case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_n = SAMPLE;
          cnt_n   = '0;
          code_n  = '0;
        end
      end
      SAMPLE: begin
        if (cnt == CW'(SAMPLE_CYCLES - 1)) begin
          state_n = TRIAL;
          cnt_n   = '0;
          idx_n   = IW'(NBITS - 1);
          code_n  = {1'b1, {(NBITS-1){1'b0}}};
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      TRIAL: begin
        if (cnt == CW'(SETTLE_CYCLES - 1)) begin
          cnt_n       = '0;
          // Decision edge: keep or clear the bit under test, then arm the next one.
          code_n[idx] = bus.cmp_in;
          if (idx != '0) begin
            code_n[idx - 1'b1] = 1'b1;
            idx_n              = idx - 1'b1;
          end else begin
            state_n = DONE;
            res_n   = code_n;
`ifdef SAR_SATFLAG_EN
            sat_n   = (code_n == '0) || (code_n == '1);
`endif
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        code_n  = '0;
      end
      default: state_n = IDLE;
    endcase
    // Abort overrides everything the FSM decided this cycle; the result register is
    // only written on the final decision edge, so restoring it here keeps it intact.
    if (bus.abort && state != IDLE) begin
      state_n = IDLE;
      cnt_n   = '0;
      idx_n   = '0;
      code_n  = '0;
      res_n   = res;
`ifdef SAR_SATFLAG_EN
      sat_n   = sat;
`endif
    end
  end

  // Status outputs decode straight from the state register so reset clears them at once.
  assign bus.sample   = (state == SAMPLE);
  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);
  assign bus.dac_code = code;
  assign bus.result   = res;
`ifdef SAR_SATFLAG_EN
  assign bus.sat      = sat;
`endif

endmodule
